// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/stage-control unit.
package pipe_ctrl_pkg;

  typedef logic [1:0] state_t;
  localparam state_t RUN   = 2'd0;
  localparam state_t STALL = 2'd1;
  localparam state_t FLUSH = 2'd2;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_X  = 2'b01;
  localparam logic [1:0] FWD_WB = 2'b10;

  localparam logic [7:0] NOP_INSTR = 8'b00001010;

  // Shadow entries carry the widest supported register index; narrower
  // indices are zero-extended on the way in.
  localparam int REG_IDX_W = 4;
  typedef logic [REG_IDX_W-1:0] reg_idx_t;

  typedef struct packed {
    logic     valid;
    logic     wr;
    reg_idx_t rd;
    logic     is_load;
  } shadow_t;

  function automatic logic src_match(input shadow_t e, input logic used, input reg_idx_t src);
    return used && e.valid && e.wr && (e.rd == src);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clock) begin
    if (!reset)
      count <= '0;
    else if (clr)
      count <= '0;
    else if (inc && (count != '1))
      count <= count + WIDTH'(1);
  end

endmodule

// File: rtl/pipe_hazard_unit.sv
// Hazard detection, operand forwarding and stage-load control for the
// 4-stage core, driven by a two-entry shadow of the X and WB stages.
module pipe_hazard_unit
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W  = 2,
  parameter int CNT_W       = 16,
  parameter int FLUSH_SLOTS = 1,
  parameter int FWD_EN      = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  hold,
  input  logic                  rf_valid,
  input  logic [REG_ADDR_W-1:0] rf_rs1,
  input  logic [REG_ADDR_W-1:0] rf_rs2,
  input  logic                  rf_rs1_used,
  input  logic                  rf_rs2_used,
  input  logic                  rf_wr,
  input  logic [REG_ADDR_W-1:0] rf_rd,
  input  logic                  rf_is_load,
  input  logic                  br_taken,
  input  logic                  clr_cnt,
  output logic                  pc_write,
  output logic                  s1_load,
  output logic                  s2_load,
  output logic                  s3_load,
  output logic                  s4_load,
  output logic [3:0]            nop_sel,
  output logic [1:0]            fwd_a,
  output logic [1:0]            fwd_b,
  output logic                  busy,
  output logic [CNT_W-1:0]      cycle_cnt,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt
);

  shadow_t  x_q, wb_q, rf_entry;
  state_t   state_q, mode;
  logic [1:0] flush_left;
  reg_idx_t rs1_idx, rs2_idx;
  logic x_a, x_b, wb_a, wb_b;
  logic stall_cond, flush_active, branch_go;

  assign rs1_idx  = reg_idx_t'(rf_rs1);
  assign rs2_idx  = reg_idx_t'(rf_rs2);
  assign rf_entry = '{valid: rf_valid, wr: rf_wr, rd: reg_idx_t'(rf_rd), is_load: rf_is_load};

  assign x_a  = rf_valid && src_match(x_q,  rf_rs1_used, rs1_idx);
  assign x_b  = rf_valid && src_match(x_q,  rf_rs2_used, rs2_idx);
  assign wb_a = rf_valid && src_match(wb_q, rf_rs1_used, rs1_idx);
  assign wb_b = rf_valid && src_match(wb_q, rf_rs2_used, rs2_idx);

  // Stalls are resolved in the same cycle the dependent instruction sits in
  // RF, so STALL is never held in state_q; it only appears in mode.
  assign stall_cond = (FWD_EN != 0) ? ((x_a || x_b) && x_q.is_load)
                                    : (x_a || x_b || wb_a || wb_b);
  assign flush_active = (state_q == FLUSH) && !stall_cond;
  assign branch_go    = (state_q == RUN) && br_taken && !stall_cond;

  always_comb begin
    mode = RUN;
    if (stall_cond)
      mode = STALL;
    else if (state_q == FLUSH)
      mode = FLUSH;
  end

  assign busy = reset && (mode != RUN);

  always_comb begin
    pc_write = 1'b1;
    s1_load  = 1'b1;
    s2_load  = 1'b1;
    s3_load  = 1'b1;
    s4_load  = 1'b1;
    nop_sel  = 4'b0000;
    fwd_a    = FWD_RF;
    fwd_b    = FWD_RF;
    if (reset) begin
      if (FWD_EN != 0) begin
        fwd_a = x_a ? FWD_X : (wb_a ? FWD_WB : FWD_RF);
        fwd_b = x_b ? FWD_X : (wb_b ? FWD_WB : FWD_RF);
      end
      if (hold) begin
        pc_write = 1'b0;
        s1_load  = 1'b0;
        s2_load  = 1'b0;
        s3_load  = 1'b0;
        s4_load  = 1'b0;
      end else if (stall_cond) begin
        pc_write   = 1'b0;
        s1_load    = 1'b0;
        s2_load    = 1'b0;
        nop_sel[2] = 1'b1;
      end else begin
        nop_sel[0] = flush_active;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      x_q        <= '0;
      wb_q       <= '0;
      state_q    <= RUN;
      flush_left <= '0;
    end else if (!hold) begin
      if (s3_load)
        x_q <= nop_sel[2] ? '0 : rf_entry;
      if (s4_load)
        wb_q <= x_q;
      if (branch_go) begin
        state_q    <= FLUSH;
        flush_left <= 2'(FLUSH_SLOTS);
      end else if (flush_active) begin
        flush_left <= flush_left - 2'd1;
        if (flush_left == 2'd1)
          state_q <= RUN;
      end
    end
  end

  sat_counter #(.WIDTH(CNT_W)) u_cycle_cnt (
    .clock(clock), .reset(reset), .inc(!hold), .clr(clr_cnt), .count(cycle_cnt)
  );

  sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
    .clock(clock), .reset(reset), .inc(!hold && stall_cond), .clr(clr_cnt), .count(stall_cnt)
  );

  sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
    .clock(clock), .reset(reset), .inc(!hold && flush_active), .clr(clr_cnt), .count(flush_cnt)
  );

endmodule
